// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: buffers one host command frame (addr, len, payload) and replays it
// onto the control bus as a one-cycle mask strobe followed by one payload byte per clock.
module cmd_dispatcher #(
    parameter int N_TARGETS = 8,
    parameter int MAX_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           cmd,
    output logic [N_TARGETS-1:0] mask,
    input  logic [N_TARGETS-1:0] cmd_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);
    localparam logic [7:0] N_T = 8'(N_TARGETS);

    typedef enum logic [2:0] {IDLE, LEN, LOAD, STROBE, BURST, DRAIN} state_t;

    state_t state_q, state_d;
    logic [7:0] addr_q, addr_d, len_q, len_d, cnt_q, cnt_d, cmd_q, cmd_d;
    logic [N_TARGETS-1:0] mask_q, mask_d, sel;
    logic rx_ready_q, rx_ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] mem_q [MAX_LEN];
    logic acc, last, ack, wr_en;
    logic [IW-1:0] idx;

    // sel is zero for out-of-range addresses, which never reach STROBE anyway
    assign sel  = N_TARGETS'(1) << addr_q;
    assign ack  = |(cmd_ack & sel);
    assign acc  = rx_valid && rx_ready_q;
    assign last = cnt_q == len_q - 8'd1;
    assign idx  = cnt_q[IW-1:0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        cmd_d      = 8'h00;
        mask_d     = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                addr_d     = rx_data;
                err_code_d = 2'd0;
                busy_d     = 1'b1;
                state_d    = LEN;
            end
            LEN: if (acc) begin
                len_d = rx_data;
                cnt_d = 8'd0;
                if (rx_data == 8'd0) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (rx_data > MAX_L) begin
                    err_code_d = 2'd2;
                    state_d    = DRAIN;
                end else if (addr_q >= N_T) begin
                    err_code_d = 2'd1;
                    state_d    = DRAIN;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: if (acc) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (last) begin
                    mask_d  = sel;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                cmd_d   = mem_q[0];
                cnt_d   = 8'd0;
                state_d = BURST;
            end
            BURST: begin
                if (!ack) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    cmd_d = mem_q[idx + IW'(1)];
                end
            end
            DRAIN: if (acc) begin
                cnt_d = cnt_q + 8'd1;
                if (last) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rx_ready_d = state_d inside {IDLE, LEN, LOAD, DRAIN};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            len_q      <= 8'h00;
            cnt_q      <= 8'h00;
            cmd_q      <= 8'h00;
            mask_q     <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            mask_q     <= mask_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx] <= rx_data;
    end

    assign rx_ready = rx_ready_q;
    assign cmd      = cmd_q;
    assign mask     = mask_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed and randomized frames checked against a frame-level timing
// model, with registered slave models that acknowledge and capture the burst.
module tb_cmd_dispatcher;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic rx_ready;
    logic [7:0] cmd;
    logic [7:0] mask, cmd_ack;
    logic busy, done, err;
    logic [1:0] err_code;

    int checks = 0, failures = 0;
    int drop_k = -1;
    int done_cnt = 0, strobe_cnt = 0, exp_done = 0, exp_strobe = 0;
    logic [7:0] act;
    int pos [8];
    logic [39:0] sreg;
    logic [7:0] pl [16];

    always #5 clk = ~clk;

    cmd_dispatcher #(.N_TARGETS(8), .MAX_LEN(8)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .cmd(cmd), .mask(mask), .cmd_ack(cmd_ack),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    // Slaves: selected by mask at cycle S, ack and sample cmd from S+1; slave 2 keeps 5 bytes
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            act  <= '0;
            sreg <= '0;
            for (int i = 0; i < 8; i++) pos[i] <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    act[i] <= 1'b1;
                    pos[i] <= 0;
                    if (i == 2) sreg <= '0;
                end else if (act[i]) begin
                    pos[i] <= pos[i] + 1;
                    if (i == 2 && pos[i] < 5) sreg <= {sreg[31:0], cmd};
                end
            end
        end
    end

    always_comb begin
        cmd_ack = '0;
        for (int i = 0; i < 8; i++) cmd_ack[i] = act[i] && (pos[i] != drop_k);
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mask != 8'h00) strobe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_payload;
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            step;
            t++;
        end
        if (t == 50) chk("ready_timeout", rx_ready, 1);
        step;
    endtask

    // One frame: expected outcome derived from the frame rules, timed from the last byte (T)
    task automatic run_frame(input int a, input int l, input int drop, input int stall);
        int nb, code;
        logic [7:0] b;
        code = (l == 0 || l > 8) ? 2 : (a >= 8) ? 1 : 0;
        nb = (l == 0) ? 2 : l + 2;
        drop_k = drop;
        for (int i = 0; i < nb; i++) begin
            b = (i == 0) ? 8'(a) : (i == 1) ? 8'(l) : pl[i-2];
            while (stall != 0 && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                step;
                if (i > 0) chk("ready_in_gap", rx_ready, 1);
            end
            send_byte(b);
            if (i == 0) begin
                chk("busy_after_addr", busy, 1);
                chk("code_cleared", err_code, 0);
            end
        end
        rx_valid = 1'b0;
        if (code != 0) begin
            chk("err_pulse", err, 1);
            chk("err_code", err_code, code);
            chk("busy_on_err", busy, 0);
            chk("ready_on_err", rx_ready, 1);
        end else begin
            exp_strobe++;
            chk("strobe_mask", mask, 32'(1) << a);
            chk("strobe_cmd", cmd, 0);
            chk("strobe_ready", rx_ready, 0);
            step;
            for (int k = 0; k < l; k++) begin
                chk("burst_cmd", cmd, pl[k]);
                chk("burst_mask", mask, 0);
                chk("burst_ready", rx_ready, 0);
                step;
                if (k == drop) begin
                    chk("ack_err", err, 1);
                    chk("ack_code", err_code, 3);
                    chk("ack_cmd_zero", cmd, 0);
                    chk("ack_busy", busy, 0);
                    chk("ack_ready", rx_ready, 1);
                    return;
                end
            end
            exp_done++;
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_ready", rx_ready, 1);
            chk("done_code", err_code, 0);
            chk("done_cmd", cmd, 0);
        end
    endtask

    initial begin
        int a, l, drop;
        step;
        step;
        chk("rst_ready", rx_ready, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_mask", mask, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        reset = 1'b0;
        chk("ready_before_edge", rx_ready, 0);
        step;
        chk("ready_after_edge", rx_ready, 1);

        pl[0] = 8'h00; pl[1] = 8'h00; pl[2] = 8'h01; pl[3] = 8'hF4; pl[4] = 8'h04;
        run_frame(2, 5, -1, 0);
        chk("slave_value", sreg[39:8], 32'h000001F4);
        chk("slave_setting", sreg[7:0], 8'h04);

        fill_payload;
        run_frame(9, 3, -1, 0);
        run_frame(1, 0, -1, 0);
        run_frame(3, 9, -1, 0);
        run_frame(4, 6, 2, 0);

        fill_payload;
        run_frame(0, 8, -1, 1);
        fill_payload;
        run_frame(7, 3, -1, 1);

        fill_payload;
        drop_k = -1;
        send_byte(8'd1);
        send_byte(8'd4);
        for (int i = 0; i < 4; i++) send_byte(pl[i]);
        rx_valid = 1'b0;
        exp_strobe++;
        step;
        step;
        chk("pre_reset_cmd", cmd, pl[1]);
        reset = 1'b1;
        #1;
        chk("async_mask", mask, 0);
        chk("async_cmd", cmd, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", rx_ready, 0);
        step;
        reset = 1'b0;
        step;
        chk("ready_after_rst", rx_ready, 1);
        fill_payload;
        run_frame(5, 6, -1, 0);

        for (int n = 0; n < 10; n++) begin
            fill_payload;
            a = $urandom_range(0, 9);
            l = $urandom_range(0, 10);
            drop = (l > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
            run_frame(a, l, drop, 1);
        end

        step;
        step;
        chk("done_count", done_cnt, exp_done);
        chk("strobe_count", strobe_cnt, exp_strobe);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
